// File: rtl/pfu_stage_pkg.sv
// Shared types for the prefetch unit: fetch-queue entry layout and SOFID encodings.
`ifndef SOFID_RANGE
`define SOFID_RANGE [0:0]
`endif
`ifndef SOFID_RUN
`define SOFID_RUN 1'b0
`endif
`ifndef SOFID_JUMP
`define SOFID_JUMP 1'b1
`endif

package pfu_stage_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic `SOFID_RANGE sofid;
        logic [XLEN-1:0]   ins;
        logic              ferr;
        logic [XLEN-1:0]   pc;
    } fq_entry_t;
endpackage

// File: rtl/pfu_fifo.sv
// DEPTH-entry fetch queue with synchronous flush; head is read straight from storage.
module pfu_fifo
    import pfu_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clk_en_i,
    input  logic          flush,
    input  logic          push,
    input  fq_entry_t     din,
    input  logic          pop,
    output fq_entry_t     head,
    output logic [CW-1:0] count,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    fq_entry_t        mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clk_en_i) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clk_en_i && push && !flush) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
endmodule

// File: rtl/pfu_stage.sv
// Prefetch unit: sequential fetch issue with credit control, in-order response queue,
// and vector flush that drops responses still owed to the old stream.
module pfu_stage
    import pfu_stage_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clk_en_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [31:0]       imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic              imem_rsp_err_i,
    input  logic [31:0]       imem_rsp_data_i,
    input  logic              exs_pc_wr_i,
    input  logic [31:0]       exs_pc_din_i,
    output logic              ids_dav_o,
    input  logic              ids_ack_i,
    output logic `SOFID_RANGE ids_sofid_o,
    output logic [31:0]       ids_ins_o,
    output logic              ids_ferr_o,
    output logic [31:0]       ids_pc_o
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   req_pc_q, rsp_pc_q, vec_pc;
    logic          sof_pending_q;
    logic [CW-1:0] inflight_q, discard_q, count_q;
    logic          credit, req_fire, rsp_fire, push, pop, vec, empty;
    fq_entry_t     wr_entry, head;

    assign vec      = exs_pc_wr_i & clk_en_i;
    assign vec_pc   = {exs_pc_din_i[31:2], 2'b00};
    assign credit   = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);

    assign imem_req_valid_o = credit & ~exs_pc_wr_i & clk_en_i & ~reset_i;
    assign imem_req_addr_o  = req_pc_q;

    assign req_fire = imem_req_valid_o & imem_req_ready_i;
    assign rsp_fire = imem_rsp_valid_i & clk_en_i;
    assign push     = rsp_fire & ~vec & (discard_q == '0);
    assign pop      = ids_dav_o & ids_ack_i & clk_en_i & ~vec;

    always_comb begin
        wr_entry       = '0;
        wr_entry.sofid = sof_pending_q ? `SOFID_JUMP : `SOFID_RUN;
        wr_entry.ins   = imem_rsp_data_i;
        wr_entry.ferr  = imem_rsp_err_i;
        wr_entry.pc    = rsp_pc_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            req_pc_q      <= RESET_VECTOR;
            rsp_pc_q      <= RESET_VECTOR;
            sof_pending_q <= 1'b1;
            inflight_q    <= '0;
            discard_q     <= '0;
        end else if (clk_en_i) begin
            // inflight_q counts every outstanding request, discarded ones included
            inflight_q <= inflight_q + CW'(req_fire) - CW'(rsp_fire);
            if (exs_pc_wr_i) begin
                req_pc_q      <= vec_pc;
                rsp_pc_q      <= vec_pc;
                sof_pending_q <= 1'b1;
                // so everything still owed after this cycle belongs to a dead stream
                discard_q     <= inflight_q - CW'(rsp_fire);
            end else begin
                if (req_fire) req_pc_q <= req_pc_q + 32'd4;
                if (push) begin
                    rsp_pc_q      <= rsp_pc_q + 32'd4;
                    sof_pending_q <= 1'b0;
                end else if (rsp_fire) begin
                    discard_q <= discard_q - 1'b1;
                end
            end
        end
    end

    pfu_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fq (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clk_en_i (clk_en_i),
        .flush    (vec),
        .push     (push),
        .din      (wr_entry),
        .pop      (pop),
        .head     (head),
        .count    (count_q),
        .empty    (empty)
    );

    assign ids_dav_o   = ~empty;
    assign ids_sofid_o = head.sofid;
    assign ids_ins_o   = head.ins;
    assign ids_ferr_o  = head.ferr;
    assign ids_pc_o    = head.pc;
endmodule

// File: tb/tb_pfu_stage.sv
// Directed bench for pfu_stage with an in-order, fixed-latency instruction memory model.
module tb_pfu_stage;
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset_i, clk_en_i;
    logic        imem_req_valid_o, imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i, imem_rsp_err_i;
    logic [31:0] imem_rsp_data_i;
    logic        exs_pc_wr_i;
    logic [31:0] exs_pc_din_i;
    logic        ids_dav_o, ids_ack_i, ids_ferr_o;
    logic [0:0]  ids_sofid_o;
    logic [31:0] ids_ins_o, ids_pc_o;

    always #5 clk = ~clk;

    pfu_stage dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .clk_en_i         (clk_en_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .exs_pc_wr_i      (exs_pc_wr_i),
        .exs_pc_din_i     (exs_pc_din_i),
        .ids_dav_o        (ids_dav_o),
        .ids_ack_i        (ids_ack_i),
        .ids_sofid_o      (ids_sofid_o),
        .ids_ins_o        (ids_ins_o),
        .ids_ferr_o       (ids_ferr_o),
        .ids_pc_o         (ids_pc_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        sof;
        logic        ferr;
    } obs_t;

    int          nchk = 0, npass = 0;
    int          cyc = 0, lat = 1, first_dav = -1, base = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] req_log[$];
    int          req_cyc[$];
    obs_t        obs[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else npass++;
    endtask

    // Memory model and id-side monitor: drive at negedge+1, observe at negedge+3.
    always begin
        @(negedge clk);
        #1;
        if (reset_i) begin
            mq_addr.delete();
            mq_due.delete();
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
            imem_rsp_err_i   = 1'b0;
        end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mq_addr[0] ^ KEY;
            imem_rsp_err_i   = (mq_addr[0] == err_addr);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
            imem_rsp_err_i   = 1'b0;
        end
        #2;
        if (!reset_i) begin
            if (imem_req_valid_o && imem_req_ready_i) begin
                mq_addr.push_back(imem_req_addr_o);
                mq_due.push_back(cyc + lat);
                req_log.push_back(imem_req_addr_o);
                req_cyc.push_back(cyc);
            end
            if (imem_rsp_valid_i) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (ids_dav_o && ids_ack_i && !exs_pc_wr_i)
                obs.push_back('{ids_pc_o, ids_ins_o, ids_sofid_o[0], ids_ferr_o});
            if (ids_dav_o && first_dav < 0) first_dav = cyc;
        end
        cyc++;
    end

    task automatic do_reset(input int l, input logic ack);
        reset_i   = 1'b1;
        lat       = l;
        ids_ack_i = ack;
        repeat (2) @(negedge clk);
        req_log.delete();
        req_cyc.delete();
        obs.delete();
        first_dav = -1;
        reset_i   = 1'b0;
        base      = cyc;
    endtask

    task automatic vec(input logic [31:0] a);
        exs_pc_wr_i  = 1'b1;
        exs_pc_din_i = a;
        @(negedge clk);
        exs_pc_wr_i  = 1'b0;
    endtask

    initial begin
        int ridx, oidx, bad;
        reset_i = 1'b1; clk_en_i = 1'b1; imem_req_ready_i = 1'b1;
        exs_pc_wr_i = 1'b0; exs_pc_din_i = '0; ids_ack_i = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid_o, 0);
        chk("rst_req_addr", imem_req_addr_o, 32'h0);
        chk("rst_dav", ids_dav_o, 0);

        // streaming, latency 1, error on 0x8
        err_addr = 32'h8;
        do_reset(1, 1'b1);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_req_addr%0d", i), req_log[i], 32'(i * 4));
            chk($sformatf("t1_req_cyc%0d", i), req_cyc[i], base + i);
        end
        chk("t1_first_dav", first_dav, base + 2);
        chk("t1_obs_n_ge4", obs.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_pc%0d", i), obs[i].pc, 32'(i * 4));
            chk($sformatf("t1_sof%0d", i), obs[i].sof, (i == 0));
            chk($sformatf("t1_ferr%0d", i), obs[i].ferr, (i == 2));
        end
        chk("t1_ins1", obs[1].ins, 32'h4 ^ KEY);
        err_addr = 32'hFFFF_FFFF;

        // back-pressure: queue fills, credit blocks further requests
        do_reset(1, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        chk("t2_req_n", req_log.size(), 4);
        chk("t2_req_valid", imem_req_valid_o, 0);
        chk("t2_dav", ids_dav_o, 1);
        chk("t2_head_pc", ids_pc_o, 32'h0);
        chk("t2_head_sof", ids_sofid_o, 1);
        ids_ack_i = 1'b1;
        @(negedge clk);
        ids_ack_i = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("t2_req_n2", req_log.size(), 5);
        chk("t2_req4", req_log[4], 32'h10);
        chk("t2_obs_n", obs.size(), 1);
        chk("t2_req_valid2", imem_req_valid_o, 0);
        chk("t2_head_pc2", ids_pc_o, 32'h4);

        // vector with 3 stale fetches in flight, latency 5
        do_reset(5, 1'b1);
        repeat (3) @(negedge clk);
        vec(32'h100);
        repeat (20) @(negedge clk);
        chk("t3_obs_n_ge3", obs.size() >= 3, 1);
        chk("t3_pc0", obs[0].pc, 32'h100);
        chk("t3_sof0", obs[0].sof, 1);
        chk("t3_ins0", obs[0].ins, 32'h100 ^ KEY);
        chk("t3_pc1", obs[1].pc, 32'h104);
        chk("t3_sof1", obs[1].sof, 0);
        bad = 0;
        foreach (obs[i]) if (obs[i].pc < 32'h100) bad++;
        chk("t3_stale", bad, 0);

        // vector with misaligned target, colliding with a response and an ack
        do_reset(1, 1'b1);
        repeat (5) @(negedge clk);
        ridx = req_log.size();
        oidx = obs.size();
        vec(32'h203);
        #1;
        chk("t4_dav_flushed", ids_dav_o, 0);
        repeat (8) @(negedge clk);
        chk("t4_oidx", oidx, 3);
        chk("t4_req_addr", req_log[ridx], 32'h200);
        chk("t4_pc_before", obs[oidx-1].pc, 32'h8);
        chk("t4_pc0", obs[oidx].pc, 32'h200);
        chk("t4_sof0", obs[oidx].sof, 1);
        chk("t4_pc1", obs[oidx+1].pc, 32'h204);

        // two vectors two cycles apart, latency 4
        do_reset(4, 1'b1);
        repeat (2) @(negedge clk);
        vec(32'h300);
        @(negedge clk);
        vec(32'h400);
        repeat (25) @(negedge clk);
        chk("t5_obs_n_ge3", obs.size() >= 3, 1);
        chk("t5_pc0", obs[0].pc, 32'h400);
        chk("t5_sof0", obs[0].sof, 1);
        chk("t5_pc1", obs[1].pc, 32'h404);
        chk("t5_sof1", obs[1].sof, 0);
        bad = 0;
        foreach (obs[i]) if (obs[i].pc < 32'h400) bad++;
        chk("t5_stale", bad, 0);
        chk("t5_discard", 32'(dut.discard_q), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
